// File: rtl/effect_param_ctrl_pkg.sv
// effect_ctrl_pkg: shared types, widths and saturating helpers for the effect
// parameter controller. Used by effect_param_ctrl and, when the mute-on-toggle
// build option EFFECT_CTRL_MUTE_ON_TOGGLE_EN is defined, by sample_counter.
package effect_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        MUTE_PRE,
        MUTE_POST
    } ctrl_state_t;

    typedef enum logic [1:0] {
        OP_SEL,
        OP_UP,
        OP_DOWN,
        OP_TOGGLE
    } ctrl_op_t;

    localparam int DEFAULT_LEVEL_W = 3;

    // Helpers work on a fixed wide container so any LEVEL_W up to this fits.
    localparam int MAX_LEVEL_W = 16;

    // Wide enough for the largest supported mute length (1023 samples).
    localparam int MUTE_CNT_W = 10;

    // Increment that sticks at maxValue instead of wrapping.
    function automatic logic [MAX_LEVEL_W-1:0] sat_inc(
        input logic [MAX_LEVEL_W-1:0] value,
        input logic [MAX_LEVEL_W-1:0] maxValue
    );
        if (value >= maxValue) begin
            return maxValue;
        end
        return value + MAX_LEVEL_W'(1);
    endfunction

    // Decrement that sticks at zero instead of wrapping.
    function automatic logic [MAX_LEVEL_W-1:0] sat_dec(
        input logic [MAX_LEVEL_W-1:0] value
    );
        if (value == '0) begin
            return '0;
        end
        return value - MAX_LEVEL_W'(1);
    endfunction

endpackage

// File: rtl/effect_param_ctrl_sample_counter.sv
// sample_counter: counts sample strobes up to TERMINAL and flags the strobe
// that completes the count, clearing itself on that same strobe.
// Only exists when EFFECT_CTRL_MUTE_ON_TOGGLE_EN is defined; without the mute
// feature the controller has no use for it, so nothing is compiled here.
`ifdef EFFECT_CTRL_MUTE_ON_TOGGLE_EN
module sample_counter
    import effect_ctrl_pkg::*;
#(
    parameter int TERMINAL = 64
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_count_en,
    input  logic i_valid,
    output logic o_terminal
);

    logic [MUTE_CNT_W-1:0] r_count;
    logic                  w_atTerminal;

    assign w_atTerminal = (r_count == MUTE_CNT_W'(TERMINAL - 1));
    assign o_terminal   = i_count_en & i_valid & w_atTerminal;

    // Count strobes while enabled; the terminal strobe wraps back to zero.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_count <= '0;
        end else if (i_count_en && i_valid) begin
            if (w_atTerminal) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + MUTE_CNT_W'(1);
            end
        end
    end

endmodule
`endif

// File: rtl/effect_param_ctrl.sv
// effect_param_ctrl: turns front-panel key pulses into per-slot enable/level
// registers for the effect chain. Changes are committed only on a sample
// strobe so no stage sees a parameter move in the middle of a sample.
// Build option EFFECT_CTRL_MUTE_ON_TOGGLE_EN: when defined, an enable toggle
// is wrapped in MUTE_SAMPLES muted samples before and after the flip.
module effect_param_ctrl
    import effect_ctrl_pkg::*;
#(
    parameter int N_SLOTS      = 4,
    parameter int LEVEL_W      = DEFAULT_LEVEL_W,
    parameter int MUTE_SAMPLES = 64
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_valid,
    input  logic                         i_key_sel,
    input  logic                         i_key_up,
    input  logic                         i_key_down,
    input  logic                         i_key_toggle,
    output logic [N_SLOTS-1:0]           o_enable,
    output logic [N_SLOTS*LEVEL_W-1:0]   o_level,
    output logic [$clog2(N_SLOTS)-1:0]   o_sel,
    output logic                         o_mute,
    output logic                         o_busy
);

    localparam int SEL_W = $clog2(N_SLOTS);
    localparam logic [MAX_LEVEL_W-1:0] LEVEL_MAX = MAX_LEVEL_W'((1 << LEVEL_W) - 1);

    // Refuse to elaborate with a configuration the logic was not sized for.
    if (N_SLOTS < 2 || N_SLOTS > 8 || LEVEL_W < 1 || LEVEL_W > MAX_LEVEL_W ||
        MUTE_SAMPLES < 1 || MUTE_SAMPLES > 1023) begin : g_paramCheck
        $error("effect_param_ctrl: parameter out of supported range");
    end

    ctrl_state_t              r_state;
    ctrl_op_t                 r_op;
    logic [SEL_W-1:0]         r_slot;
    logic [SEL_W-1:0]         r_sel;
    logic [N_SLOTS-1:0]       r_enable;
    logic [N_SLOTS*LEVEL_W-1:0] r_level;

    logic                     w_anyKey;
    ctrl_op_t                 w_keyOp;
    logic [LEVEL_W-1:0]       w_curLevel;
    logic [LEVEL_W-1:0]       w_incLevel;
    logic [LEVEL_W-1:0]       w_decLevel;
    logic [SEL_W-1:0]         w_nextSel;
    logic [N_SLOTS-1:0]       w_slotMask;

    assign w_anyKey   = i_key_sel | i_key_up | i_key_down | i_key_toggle;
    assign w_curLevel = r_level[r_slot*LEVEL_W +: LEVEL_W];
    assign w_incLevel = LEVEL_W'(sat_inc(MAX_LEVEL_W'(w_curLevel), LEVEL_MAX));
    assign w_decLevel = LEVEL_W'(sat_dec(MAX_LEVEL_W'(w_curLevel)));
    assign w_nextSel  = (r_sel == SEL_W'(N_SLOTS - 1)) ? '0 : r_sel + SEL_W'(1);
    assign w_slotMask = N_SLOTS'(1) << r_slot;

    // Pick one key when several pulse together: toggle > up > down > sel.
    always_comb begin
        w_keyOp = OP_SEL;
        if (i_key_toggle) begin
            w_keyOp = OP_TOGGLE;
        end else if (i_key_up) begin
            w_keyOp = OP_UP;
        end else if (i_key_down) begin
            w_keyOp = OP_DOWN;
        end
    end

`ifdef EFFECT_CTRL_MUTE_ON_TOGGLE_EN
    logic r_mute;
    logic w_muteTerminal;
    logic w_muteCountEn;
    logic w_muteClear;

    assign w_muteCountEn = (r_state == MUTE_PRE) || (r_state == MUTE_POST);
    assign w_muteClear   = (r_state == PENDING);

    sample_counter #(
        .TERMINAL (MUTE_SAMPLES)
    ) u_muteCounter (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clear    (w_muteClear),
        .i_count_en (w_muteCountEn),
        .i_valid    (i_valid),
        .o_terminal (w_muteTerminal)
    );

    assign o_mute = r_mute;
`else
    assign o_mute = 1'b0;
`endif

    // Control FSM: latch one key in IDLE, commit it on the next sample strobe.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_op     <= OP_SEL;
            r_slot   <= '0;
            r_sel    <= '0;
            r_enable <= '0;
            r_level  <= '0;
`ifdef EFFECT_CTRL_MUTE_ON_TOGGLE_EN
            r_mute   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_anyKey) begin
                        r_op    <= w_keyOp;
                        r_slot  <= r_sel;
                        r_state <= PENDING;
                    end
                end
                PENDING: begin
                    if (i_valid) begin
                        r_state <= IDLE;
                        case (r_op)
                            OP_SEL:  r_sel <= w_nextSel;
                            OP_UP:   r_level[r_slot*LEVEL_W +: LEVEL_W] <= w_incLevel;
                            OP_DOWN: r_level[r_slot*LEVEL_W +: LEVEL_W] <= w_decLevel;
                            OP_TOGGLE: begin
`ifdef EFFECT_CTRL_MUTE_ON_TOGGLE_EN
                                r_state <= MUTE_PRE;
                                r_mute  <= 1'b1;
`else
                                r_enable <= r_enable ^ w_slotMask;
`endif
                            end
                            default: r_state <= IDLE;
                        endcase
                    end
                end
`ifdef EFFECT_CTRL_MUTE_ON_TOGGLE_EN
                MUTE_PRE: begin
                    if (w_muteTerminal) begin
                        r_enable <= r_enable ^ w_slotMask;
                        r_state  <= MUTE_POST;
                    end
                end
                MUTE_POST: begin
                    if (w_muteTerminal) begin
                        r_mute  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_enable = r_enable;
    assign o_level  = r_level;
    assign o_sel    = r_sel;
    assign o_busy   = (r_state != IDLE);

endmodule

// File: tb/tb_effect_param_ctrl.sv
// tb_effect_param_ctrl: directed self-checking bench for effect_param_ctrl.
// Follows the default build; with EFFECT_CTRL_MUTE_ON_TOGGLE_EN defined it
// also exercises the muted toggle sequence with MUTE_SAMPLES=4.
module tb_effect_param_ctrl;

    localparam int NS = 4;
    localparam int LW = 3;
`ifdef EFFECT_CTRL_MUTE_ON_TOGGLE_EN
    localparam int MS = 4;
`else
    localparam int MS = 64;
`endif

    logic              i_clk;
    logic              i_rst;
    logic              i_valid;
    logic              i_key_sel;
    logic              i_key_up;
    logic              i_key_down;
    logic              i_key_toggle;
    logic [NS-1:0]     o_enable;
    logic [NS*LW-1:0]  o_level;
    logic [1:0]        o_sel;
    logic              o_mute;
    logic              o_busy;

    int checks   = 0;
    int failures = 0;

    effect_param_ctrl #(
        .N_SLOTS      (NS),
        .LEVEL_W      (LW),
        .MUTE_SAMPLES (MS)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_valid      (i_valid),
        .i_key_sel    (i_key_sel),
        .i_key_up     (i_key_up),
        .i_key_down   (i_key_down),
        .i_key_toggle (i_key_toggle),
        .o_enable     (o_enable),
        .o_level      (o_level),
        .o_sel        (o_sel),
        .o_mute       (o_mute),
        .o_busy       (o_busy)
    );

    // Free-running 10 ns clock.
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic stepCycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) stepCycle();
    endtask

    task automatic applyStimulus(input logic tog, input logic up, input logic down, input logic sel);
        i_key_toggle = tog;
        i_key_up     = up;
        i_key_down   = down;
        i_key_sel    = sel;
        stepCycle();
        i_key_toggle = 1'b0;
        i_key_up     = 1'b0;
        i_key_down   = 1'b0;
        i_key_sel    = 1'b0;
    endtask

    task automatic validCycle();
        i_valid = 1'b1;
        stepCycle();
        i_valid = 1'b0;
    endtask

    // One sample period: fifteen quiet cycles then the strobe.
    task automatic commitOp();
        idleCycles(15);
        validCycle();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Commit a latched toggle and follow it to completion.
    task automatic commitToggle(input logic [3:0] expBefore, input logic [3:0] expAfter);
`ifdef EFFECT_CTRL_MUTE_ON_TOGGLE_EN
        validCycle();
        checkOutput("muteStartMute", 32'(o_mute), 32'd1);
        checkOutput("muteStartBusy", 32'(o_busy), 32'd1);
        checkOutput("muteStartEnable", 32'(o_enable), 32'(expBefore));
        for (int i = 1; i <= MS; i++) begin
            commitOp();
            checkOutput("mutePreEnable", 32'(o_enable), (i < MS) ? 32'(expBefore) : 32'(expAfter));
            checkOutput("mutePreMute", 32'(o_mute), 32'd1);
        end
        for (int i = 1; i <= MS; i++) begin
            commitOp();
            checkOutput("mutePostMute", 32'(o_mute), (i < MS) ? 32'd1 : 32'd0);
            checkOutput("mutePostBusy", 32'(o_busy), (i < MS) ? 32'd1 : 32'd0);
        end
`else
        validCycle();
        checkOutput("toggleEnable", 32'(o_enable), 32'(expAfter));
        checkOutput("toggleBusy", 32'(o_busy), 32'd0);
        checkOutput("toggleMute", 32'(o_mute), 32'd0);
        checks += 0;
        if (expBefore === expAfter) $display("[TB] note: toggle expected no change");
`endif
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "Enable"}, 32'(o_enable), 32'd0);
        checkOutput({tag, "Level"}, 32'(o_level), 32'd0);
        checkOutput({tag, "Sel"}, 32'(o_sel), 32'd0);
        checkOutput({tag, "Mute"}, 32'(o_mute), 32'd0);
        checkOutput({tag, "Busy"}, 32'(o_busy), 32'd0);
    endtask

    // Directed scenario sequence.
    initial begin
        logic [2:0] expLvl;
        i_rst        = 1'b1;
        i_valid      = 1'b0;
        i_key_sel    = 1'b0;
        i_key_up     = 1'b0;
        i_key_down   = 1'b0;
        i_key_toggle = 1'b0;
        idleCycles(2);
        checkAllZero("reset");
        i_rst = 1'b0;

        $display("[TB] sample strobe while idle");
        validCycle();
        checkOutput("idleValidBusy", 32'(o_busy), 32'd0);
        checkOutput("idleValidLevel", 32'(o_level), 32'd0);

        $display("[TB] toggle slot 0");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("keyBusy", 32'(o_busy), 32'd1);
        idleCycles(15);
        checkOutput("pendingBusy", 32'(o_busy), 32'd1);
        checkOutput("pendingEnable", 32'(o_enable), 32'd0);
        commitToggle(4'b0000, 4'b0001);

        $display("[TB] eight ups on slot 0");
        expLvl = 3'd0;
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
            commitOp();
            expLvl = (expLvl == 3'd7) ? 3'd7 : expLvl + 3'd1;
            checkOutput("upSeqLevel", 32'(o_level), {23'd0, 9'd0, expLvl});
        end

        $display("[TB] five selects");
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
            commitOp();
            checkOutput("selSeq", 32'(o_sel), 32'(i % NS));
        end

        $display("[TB] down at level 0 on slot 1");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        commitOp();
        checkOutput("downSatLevel", 32'(o_level), 32'h007);

        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        commitOp();
        checkOutput("upSlot1Level", 32'(o_level), 32'h00F);

        $display("[TB] up and toggle together");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        commitToggle(4'b0001, 4'b0011);
        checkOutput("prioLevel", 32'(o_level), 32'h00F);

        $display("[TB] up while busy");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        idleCycles(2);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("busyDropBusy", 32'(o_busy), 32'd1);
        commitOp();
        checkOutput("busyDropLevel", 32'(o_level), 32'h017);
        commitOp();
        checkOutput("busyDropLater", 32'(o_level), 32'h017);
        checkOutput("busyDropIdle", 32'(o_busy), 32'd0);

        $display("[TB] key on the commit edge");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        idleCycles(5);
        i_key_up = 1'b1;
        validCycle();
        i_key_up = 1'b0;
        checkOutput("edgeKeyLevel", 32'(o_level), 32'h01F);
        checkOutput("edgeKeyBusy", 32'(o_busy), 32'd0);
        commitOp();
        checkOutput("edgeKeyLater", 32'(o_level), 32'h01F);

        $display("[TB] down beats sel");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        commitOp();
        checkOutput("downPrioLevel", 32'(o_level), 32'h017);
        checkOutput("downPrioSel", 32'(o_sel), 32'd1);

        $display("[TB] reset while pending");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        idleCycles(3);
        i_rst        = 1'b1;
        i_valid      = 1'b1;
        i_key_toggle = 1'b1;
        stepCycle();
        i_rst        = 1'b0;
        i_valid      = 1'b0;
        i_key_toggle = 1'b0;
        checkAllZero("midReset");
        commitOp();
        checkOutput("midResetDiscard", 32'(o_level), 32'd0);

`ifdef EFFECT_CTRL_MUTE_ON_TOGGLE_EN
        $display("[TB] muted toggle on slot 2");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        commitOp();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        commitOp();
        checkOutput("muteSel", 32'(o_sel), 32'd2);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        commitToggle(4'b0000, 4'b0100);

        $display("[TB] reset during mute-pre");
        i_rst = 1'b1;
        stepCycle();
        i_rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        commitOp();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        commitOp();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        commitOp();
        checkOutput("preRstMute", 32'(o_mute), 32'd1);
        commitOp();
        commitOp();
        checkOutput("preRstEnable", 32'(o_enable), 32'd0);
        i_rst   = 1'b1;
        i_valid = 1'b1;
        stepCycle();
        i_rst   = 1'b0;
        i_valid = 1'b0;
        checkAllZero("muteReset");
        for (int i = 0; i < MS + 1; i++) commitOp();
        checkOutput("muteResetEnable", 32'(o_enable), 32'd0);
        checkOutput("muteResetMute", 32'(o_mute), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
